// File: rtl/alu_input_latch_if.sv
// Operand-latch bus bundle: source buses and select strobes in, latched operands and status out.
interface alu_input_latch_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sb_bus;
    logic [WIDTH-1:0] db_bus;
    logic [WIDTH-1:0] adl_bus;
    logic             zero_add;
    logic             sb_add;
    logic             db_add;
    logic             db_n_add;
    logic             adl_add;
    logic             carry_set;
    logic             alu_ack;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_in;
    logic             operands_valid;
    logic             conflict_err;
    logic [1:0]       state;

    modport master (
        output sb_bus, db_bus, adl_bus,
        output zero_add, sb_add, db_add, db_n_add, adl_add, carry_set, alu_ack,
        input  a_reg, b_reg, carry_in, operands_valid, conflict_err, state
    );

    modport slave (
        input  sb_bus, db_bus, adl_bus,
        input  zero_add, sb_add, db_add, db_n_add, adl_add, carry_set, alu_ack,
        output a_reg, b_reg, carry_in, operands_valid, conflict_err, state
    );
endinterface

// File: rtl/alu_input_latch.sv
// Purpose: latches ALU A/B operands and carry-in from selectable buses, tracks pair readiness.
// Latency: one phi_2 edge from select strobe to latched operand / state / flag.
// Backpressure: none; loads always overwrite, alu_ack in READY consumes the pair.
module alu_input_latch #(
    parameter int WIDTH      = 8,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic               phi_2,
    input  logic               rst,
    alu_input_latch_if.slave   io
);
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        READY  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             valid_q;
    logic             err_q;

    logic             a_load;
    logic             a_conf;
    logic [2:0]       b_sel;
    logic             b_load;
    logic             b_conf;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic             consumed;
    logic             have_a;
    logic             have_b;

    // A source is a one-hot pair; B source is one-hot over three strobes.
    assign a_load = io.zero_add ^ io.sb_add;
    assign a_conf = io.zero_add & io.sb_add;
    assign b_sel  = {io.db_add, io.db_n_add, io.adl_add};
    assign b_load = (b_sel != 3'd0) && ((b_sel & (b_sel - 3'd1)) == 3'd0);
    assign b_conf = (b_sel != 3'd0) && !b_load;

    always_comb begin
        a_nxt = io.sb_add ? io.sb_bus : '0;
        b_nxt = io.adl_bus;
        if (io.db_add)
            b_nxt = io.db_bus;
        else if (io.db_n_add)
            b_nxt = ~io.db_bus;
    end

    // State bit 0 marks A held, bit 1 marks B held; a consume clears both before new loads apply.
    always_comb begin
        consumed = (state_q == READY) && io.alu_ack;
        have_a   = 1'b0;
        have_b   = 1'b0;
        case (state_q)
            EMPTY:   begin have_a = 1'b0;      have_b = 1'b0;      end
            HAVE_A:  begin have_a = 1'b1;      have_b = 1'b0;      end
            HAVE_B:  begin have_a = 1'b0;      have_b = 1'b1;      end
            READY:   begin have_a = !consumed; have_b = !consumed; end
            default: begin have_a = 1'b0;      have_b = 1'b0;      end
        endcase
        state_d = state_t'({have_b | b_load, have_a | a_load});
    end

    always_ff @(posedge phi_2) begin
        if (rst) begin
            state_q <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == READY);
            if (a_load)
                a_q <= a_nxt;
            if (b_load) begin
                b_q     <= b_nxt;
                carry_q <= io.carry_set;
            end
            if (ERR_STICKY)
                err_q <= err_q | a_conf | b_conf;
            else
                err_q <= a_conf | b_conf;
        end
    end

    assign io.a_reg          = a_q;
    assign io.b_reg          = b_q;
    assign io.carry_in       = carry_q;
    assign io.operands_valid = valid_q;
    assign io.conflict_err   = err_q;
    assign io.state          = state_q;
endmodule

// File: doc/alu_input_latch.md
ALU_INPUT_LATCH -- requirements
Module: alu_input_latch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/bus width in bits.
REQ-002 SHALL have parameter ERR_STICKY, default 1; 1 = conflict_err held until reset, 0 = conflict_err pulses one cycle per conflict.
REQ-003 SHALL have phi_2 input 1: sole clock; all state updates on rising edge of phi_2.
REQ-004 SHALL have rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have sb_bus, db_bus and adl_bus inputs, each WIDTH: internal special bus, data bus and address-low bus operand sources.
REQ-006 SHALL have zero_add and sb_add inputs, each 1: select A source 0 or sb_bus.
REQ-007 SHALL have db_add, db_n_add and adl_add inputs, each 1: select B source db_bus, ~db_bus or adl_bus.
REQ-008 SHALL have carry_set input 1: carry-in value captured with the next B load.
REQ-009 SHALL have alu_ack input 1: ALU has consumed the current operand pair.
REQ-010 SHALL have a_reg and b_reg outputs, each WIDTH: latched A and B operands.
REQ-011 SHALL have carry_in output 1: latched carry-in.
REQ-012 SHALL have operands_valid output 1: A and B both loaded since the last consume.
REQ-013 SHALL have conflict_err output 1: multiple select lines asserted for one register.
REQ-014 SHALL have state output 2: FSM state, for debug.

Function
REQ-015 SHALL decode A-load = exactly one of {zero_add, sb_add}; if both are high, A SHALL be unchanged and a conflict flagged.
REQ-016 SHALL decode B-load = exactly one of {db_add, db_n_add, adl_add}; if two or more are high, B and carry_in SHALL be unchanged and a conflict flagged.
REQ-017 SHALL on a valid A-load set a_reg to 0 or sb_bus, visible the cycle after the edge (1-cycle latency).
REQ-018 SHALL on a valid B-load set b_reg to db_bus, ~db_bus or adl_bus, set carry_in to carry_set, with 1-cycle latency.
REQ-019 SHALL keep a_reg, b_reg and carry_in unchanged in cycles with no valid load.
REQ-020 SHALL implement FSM states EMPTY=0, HAVE_A=1, HAVE_B=2, READY=3, tracking which operands are loaded since the last consume.
REQ-021 SHALL transition EMPTY->HAVE_A on A-load only, EMPTY->HAVE_B on B-load only, EMPTY->READY on both.
REQ-022 SHALL transition HAVE_A->READY on B-load, and HAVE_B->READY on A-load; a repeat load of the already-held operand SHALL overwrite it with no state change.
REQ-023 SHALL assert operands_valid exactly when state==READY.
REQ-024 SHALL, in READY with alu_ack=1, consume the pair: next state = EMPTY, or HAVE_A/HAVE_B/READY if loads occur in the same cycle, with new data captured.
REQ-025 SHALL, in READY with alu_ack=0, let loads overwrite the data while state remains READY.
REQ-026 SHALL ignore alu_ack in any state other than READY, with no effect on state or data.
REQ-027 SHALL, for a conflicted register, still apply a valid load to the other register in the same cycle, with the FSM advancing for that load only.
REQ-028 SHALL, with ERR_STICKY=1, set conflict_err on the cycle after the first conflict and hold it until rst.
REQ-029 SHALL, with ERR_STICKY=0, assert conflict_err for exactly one cycle after each conflicting edge.
REQ-030 SHALL keep all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-031 SHALL, on rst=1 at a phi_2 edge, set a_reg=0, b_reg=0, carry_in=0, operands_valid=0, conflict_err=0 and state=EMPTY.
REQ-032 SHALL give rst priority over all loads and alu_ack in the same cycle; a reset mid-operation (including in READY) SHALL discard the held operands.
REQ-033 SHALL be fully operational on the first edge after rst deasserts.

Verification
REQ-034 SHALL cover this scenario: sb_bus=0x5A with sb_add; next cycle db_bus=0x3C with db_n_add and carry_set=1 -> a_reg=0x5A, state HAVE_A, then b_reg=0xC3, carry_in=1, operands_valid=1.
REQ-035 SHALL cover this scenario: zero_add and adl_add together with adl_bus=0x80 -> next cycle a_reg=0x00, b_reg=0x80, READY; alu_ack -> EMPTY, operands_valid=0.
REQ-036 SHALL cover this scenario: in READY, alu_ack plus sb_add with sb_bus=0x11 -> a_reg=0x11, state HAVE_A.
REQ-037 SHALL cover this scenario: db_add and adl_add together plus sb_add with sb_bus=0x22 -> b_reg unchanged, a_reg=0x22, conflict_err=1, held (ERR_STICKY=1) or one cycle (ERR_STICKY=0).
REQ-038 SHALL cover this scenario: in READY with a_reg=0xFF, rst plus sb_add -> a_reg=0, state EMPTY, conflict_err=0.
REQ-039 SHALL cover this scenario: alu_ack in EMPTY, then in HAVE_B -> state and data unchanged.
